// File: rtl/sclk_phase_tracker_if.sv
// Fast-command and phase-status signal bundle for sclk_phase_tracker.
// The master drives the TTC/fast-command side; the slave is the tracker.
interface sclk_phase_tracker_if #(
  parameter int PHASE_W = 2
);
  logic               ttc_bcntres;
  logic               FastCmd;
  logic [7:0]         FastCmdCode;
  logic               FastCmdAck;
  logic               phase_clr;
  logic [PHASE_W-1:0] sclkphasecnt;
  logic               phase_valid;
  logic               phase_locked;
  logic               phase_change;
  logic               ack_timeout;
  logic [15:0]        capture_cnt;

  modport master (
    output ttc_bcntres, FastCmd, FastCmdCode,
    output FastCmdAck, phase_clr,
    input  sclkphasecnt, phase_valid, phase_locked,
    input  phase_change, ack_timeout, capture_cnt
  );

  modport slave (
    input  ttc_bcntres, FastCmd, FastCmdCode,
    input  FastCmdAck, phase_clr,
    output sclkphasecnt, phase_valid, phase_locked,
    output phase_change, ack_timeout, capture_cnt
  );
endinterface

// File: rtl/sclk_phase_tracker.sv
// Captures the free-running sampling-clock phase on acknowledged
// SCLK-sync fast commands and reports valid/locked/change status.
module sclk_phase_tracker #(
  parameter int          PHASE_W     = 2,
  parameter logic [7:0]  CMD_CODE    = 8'hE4,
  parameter int          LOCK_N      = 4,
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  sclk_phase_tracker_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DECODE  = 2'd1,
    WAITACK = 2'd2,
    HOLD    = 2'd3
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(ACK_TIMEOUT - 1);
  localparam logic [7:0]  LOCK_V   = 8'(LOCK_N);
  localparam logic        LOCK_ONE = (LOCK_N == 1);

  state_t             state;
  logic [15:0]        timer;
  logic [PHASE_W-1:0] cnt_i;
  logic [PHASE_W-1:0] phase_q;
  logic               valid_q;
  logic               locked_q;
  logic               change_q;
  logic               tmo_q;
  logic [7:0]         match_q;
  logic [15:0]        cap_cnt_q;
  logic               cap_fire;
  logic [8:0]         match_inc;

  assign cap_fire  = (state == WAITACK) && bus.FastCmdAck;
  assign match_inc = {1'b0, match_q} + 9'd1;

  always_ff @(posedge clk) begin
    if (reset || bus.ttc_bcntres) begin
      cnt_i <= '0;
    end else begin
      cnt_i <= cnt_i + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      timer <= '0;
      tmo_q <= 1'b0;
    end else begin
      tmo_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.FastCmd) state <= DECODE;
        end
        DECODE: begin
          if (bus.FastCmdCode == CMD_CODE) begin
            state <= WAITACK;
            timer <= '0;
          end else begin
            state <= IDLE;
          end
        end
        WAITACK: begin
          if (bus.FastCmdAck) begin
            state <= HOLD;
          end else if (timer == TMO_LAST) begin
            tmo_q <= 1'b1;
            state <= IDLE;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        HOLD: begin
          if (!(bus.FastCmdAck || bus.FastCmd)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A clear in the same cycle as a capture discards that capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q   <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      change_q  <= 1'b0;
      match_q   <= '0;
      cap_cnt_q <= '0;
    end else begin
      change_q <= 1'b0;
      if (bus.phase_clr) begin
        phase_q   <= '0;
        valid_q   <= 1'b0;
        locked_q  <= 1'b0;
        match_q   <= '0;
        cap_cnt_q <= '0;
      end else if (cap_fire) begin
        if (cap_cnt_q != 16'hFFFF) cap_cnt_q <= cap_cnt_q + 16'd1;
        if (!valid_q) begin
          phase_q  <= cnt_i;
          valid_q  <= 1'b1;
          match_q  <= 8'd1;
          locked_q <= LOCK_ONE;
        end else if (cnt_i == phase_q) begin
          if (match_inc >= {1'b0, LOCK_V}) begin
            match_q  <= LOCK_V;
            locked_q <= 1'b1;
          end else begin
            match_q <= match_inc[7:0];
          end
        end else begin
          phase_q  <= cnt_i;
          match_q  <= 8'd1;
          locked_q <= LOCK_ONE;
          change_q <= 1'b1;
        end
      end
    end
  end

  assign bus.sclkphasecnt = phase_q;
  assign bus.phase_valid  = valid_q;
  assign bus.phase_locked = locked_q;
  assign bus.phase_change = change_q;
  assign bus.ack_timeout  = tmo_q;
  assign bus.capture_cnt  = cap_cnt_q;

endmodule

// File: doc/sclk_phase_tracker.md
Name: sclk_phase_tracker

Overview:
Measures the sampling-clock phase relative to the TTC bunch-counter reset. Each acknowledged SCLK-sync fast command captures a free-running PHASE_W-bit phase counter. Consecutive captures are compared to report valid, locked and phase-change status. Generalises the fixed 2-bit single-capture phase detector and sits beside the fast-command decoder in the SRU trigger path.

Parameters:
PHASE_W, 2, phase counter width; sampling-clock division ratio is 2^PHASE_W (legal 1..8)
CMD_CODE, 8'hE4, fast-command code that triggers a capture
LOCK_N, 4, number of consecutive identical captures required to assert lock (legal 1..255)
ACK_TIMEOUT, 16, cycles waited in WAITACK for FastCmdAck before aborting (legal 2..65535)

Ports:
clk  in  1  system clock; the only clock; all logic on its rising edge
reset  in  1  synchronous, active-high reset
ttc_bcntres  in  1  bunch-counter reset; zeroes the phase counter
FastCmd  in  1  fast-command strobe
FastCmdCode  in  8  fast-command code, valid the cycle after FastCmd
FastCmdAck  in  1  fast-command acknowledge
phase_clr  in  1  single-cycle request to clear capture history
sclkphasecnt  out  PHASE_W  last captured phase
phase_valid  out  1  at least one capture since reset/phase_clr
phase_locked  out  1  LOCK_N consecutive identical captures
phase_change  out  1  one-cycle pulse: capture differs from held phase
ack_timeout  out  1  one-cycle pulse: WAITACK expired without ack
capture_cnt  out  16  captures since reset/phase_clr, saturating at 16'hFFFF

Behaviour:
- Reset: all outputs 0, FSM = IDLE, phase counter 0, match counter 0, timeout timer 0.
- Phase counter cnt_i: PHASE_W bits, +1 every cycle, wraps 2^PHASE_W-1 -> 0. If reset or ttc_bcntres is high at an edge, cnt_i is 0 after that edge. So with ttc_bcntres high in cycle t, cnt_i = k mod 2^PHASE_W in cycle t+1+k.
- FSM states:
  IDLE: FastCmd -> DECODE.
  DECODE: FastCmdCode == CMD_CODE -> WAITACK and clear timer; otherwise -> IDLE.
  WAITACK: FastCmdAck -> capture the current cnt_i and go to HOLD. Otherwise the timer increments. When the timer equals ACK_TIMEOUT-1 without an ack: pulse ack_timeout and go to IDLE; no capture.
  HOLD: stay while FastCmdAck or FastCmd is high; otherwise -> IDLE. No captures occur in HOLD.
- Capture update (registered; outputs change at the edge ending the ack cycle):
  - phase_valid = 0: sclkphasecnt <= cap, phase_valid <= 1, match <= 1, phase_locked <= (LOCK_N == 1).
  - cap == sclkphasecnt: match <= min(match+1, LOCK_N); phase_locked <= 1 when match+1 >= LOCK_N.
  - cap != sclkphasecnt: sclkphasecnt <= cap, match <= 1, phase_locked <= (LOCK_N == 1), phase_change pulses 1 cycle.
  - capture_cnt increments on every capture, saturating.
- phase_clr: clears sclkphasecnt, phase_valid, phase_locked, match and capture_cnt to 0. It does not affect the FSM or cnt_i. If phase_clr coincides with a capture, the clear wins and the capture is discarded.
- ttc_bcntres coinciding with an ack: the captured value is the pre-reset cnt_i.
- Reset mid-operation (any state): immediate return to reset values; no pulse is emitted.
- Undefined FSM encodings recover to IDLE.

Test Plan:
- Reset -> all outputs 0; FastCmd with code 8'h12, then ack -> no capture, capture_cnt stays 0.
- PHASE_W=2: ttc_bcntres at cycle t; FastCmd at t+3, code E4 at t+4, ack at t+6 -> sclkphasecnt=1 (5 mod 4), phase_valid=1, capture_cnt=1, phase_locked=0.
- LOCK_N=4: four captures all at phase 1 -> phase_locked rises after the 4th ack edge. A 5th capture at phase 3 -> phase_change pulses once, sclkphasecnt=3, phase_locked=0.
- Code E4 with no ack for ACK_TIMEOUT=16 cycles -> ack_timeout pulses exactly once, the FSM is back in IDLE, and a later ack is ignored.
- phase_clr asserted in the same cycle as an ack -> sclkphasecnt=0, phase_valid=0, capture_cnt=0. Next command/ack at phase 2 -> sclkphasecnt=2, phase_valid=1.
- PHASE_W=3 with ack 10 cycles after ttc_bcntres -> sclkphasecnt=1 (9 mod 8). Assert reset in WAITACK -> all outputs 0, no ack_timeout pulse.
